ctrl_resolve_buffer: RTL and testbench

//  Collects resolved control-transfer results from NUM_PIPES control execution pipes (one update each per cycle)

---
 rtl/ctrl_resolve_buffer_pkg.sv | 16 +
 rtl/ctrl_resolve_buffer_age.sv | 19 +
 rtl/ctrl_resolve_buffer.sv | 145 ++++++++++++++
 tb/tb_ctrl_resolve_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_resolve_buffer_pkg.sv
// rtl/ctrl_resolve_buffer_pkg.sv - shared widths and predictor update packet for the resolve buffer
package ctrl_resolve_buffer_pkg;

   localparam int SIZE_PC         = 32;
   localparam int SIZE_CTI_LOG    = 4;
   localparam int BRANCH_TYPE_LOG = 2;

   typedef struct packed {
      logic [SIZE_PC-1:0]         pc;
      logic [SIZE_PC-1:0]         npc;
      logic [BRANCH_TYPE_LOG-1:0] ctrlType;
      logic                       dir;
      logic [SIZE_CTI_LOG-1:0]    ctiID;
   } ctrlUpdPkt;

endpackage

// File: rtl/ctrl_resolve_buffer_age.sv
// rtl/ctrl_resolve_buffer_age.sv - wrap-safe CTI age compare relative to the oldest in-flight CTI
module cti_age_younger
   import ctrl_resolve_buffer_pkg::*;
(
   input  logic [SIZE_CTI_LOG-1:0] ctiA_i,
   input  logic [SIZE_CTI_LOG-1:0] ctiB_i,
   input  logic [SIZE_CTI_LOG-1:0] head_i,
   output logic                    younger_o
);

   logic [SIZE_CTI_LOG-1:0] w_age_a;
   logic [SIZE_CTI_LOG-1:0] w_age_b;

   // Modular subtraction makes ages monotonic across the CTI ID wrap point.
   assign w_age_a   = ctiA_i - head_i;
   assign w_age_b   = ctiB_i - head_i;
   assign younger_o = (w_age_a > w_age_b);

endmodule

// File: rtl/ctrl_resolve_buffer.sv
// rtl/ctrl_resolve_buffer.sv - merges per-pipe resolved CTIs into one predictor update stream
module ctrl_resolve_buffer
   import ctrl_resolve_buffer_pkg::*;
#(
   parameter int NUM_PIPES  = 2,
   parameter int DEPTH      = 8,
   parameter int DROP_CNT_W = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 exceptionFlag_i,
   input  logic                                 recoverFlag_i,
   input  logic [SIZE_CTI_LOG-1:0]              recoverCtiID_i,
   input  logic [SIZE_CTI_LOG-1:0]              ctiHead_i,
   input  logic [NUM_PIPES-1:0]                 exeCtrlValid_i,
   input  logic [NUM_PIPES*SIZE_PC-1:0]         exeCtrlPC_i,
   input  logic [NUM_PIPES*SIZE_PC-1:0]         exeCtrlNPC_i,
   input  logic [NUM_PIPES*BRANCH_TYPE_LOG-1:0] exeCtrlType_i,
   input  logic [NUM_PIPES-1:0]                 exeCtrlDir_i,
   input  logic [NUM_PIPES*SIZE_CTI_LOG-1:0]    exeCtiID_i,
   input  logic                                 updReady_i,
   output logic                                 updValid_o,
   output ctrlUpdPkt                            updPkt_o,
   output logic [$clog2(DEPTH):0]               occupancy_o,
   output logic [DROP_CNT_W-1:0]                dropCnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   ctrlUpdPkt              r_entry [DEPTH];
   logic [DEPTH-1:0]       r_live;
   logic [PTR_W-1:0]       r_head;
   logic [PTR_W-1:0]       r_tail;
   logic [CNT_W-1:0]       r_count;
   logic [DROP_CNT_W-1:0]  r_drop_cnt;

   ctrlUpdPkt              w_in_pkt [NUM_PIPES];
   logic [NUM_PIPES-1:0]   w_in_younger;
   logic [DEPTH-1:0]       w_ent_younger;
   logic [NUM_PIPES-1:0]   w_acc;
   logic [PTR_W-1:0]       w_off [NUM_PIPES];
   logic [CNT_W-1:0]       w_used;
   logic [CNT_W-1:0]       w_drops;
   logic [CNT_W-1:0]       w_free;
   logic                   w_pop;
   logic [DROP_CNT_W:0]    w_drop_sum;
   logic [DROP_CNT_W-1:0]  w_drop_next;

   always_comb begin
      for (int p = 0; p < NUM_PIPES; p++) begin
         w_in_pkt[p].pc       = exeCtrlPC_i[p*SIZE_PC +: SIZE_PC];
         w_in_pkt[p].npc      = exeCtrlNPC_i[p*SIZE_PC +: SIZE_PC];
         w_in_pkt[p].ctrlType = exeCtrlType_i[p*BRANCH_TYPE_LOG +: BRANCH_TYPE_LOG];
         w_in_pkt[p].dir      = exeCtrlDir_i[p];
         w_in_pkt[p].ctiID    = exeCtiID_i[p*SIZE_CTI_LOG +: SIZE_CTI_LOG];
      end
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_ent_age
      cti_age_younger u_age (
         .ctiA_i    (r_entry[e].ctiID),
         .ctiB_i    (recoverCtiID_i),
         .head_i    (ctiHead_i),
         .younger_o (w_ent_younger[e])
      );
   end

   for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe_age
      cti_age_younger u_age (
         .ctiA_i    (w_in_pkt[p].ctiID),
         .ctiB_i    (recoverCtiID_i),
         .head_i    (ctiHead_i),
         .younger_o (w_in_younger[p])
      );
   end

   assign updValid_o  = (r_count != '0) && r_live[r_head];
   assign updPkt_o    = r_entry[r_head];
   assign occupancy_o = r_count;
   assign dropCnt_o   = r_drop_cnt;

   // Squashed heads retire on their own so they never stall behind the predictor.
   assign w_pop = (r_count != '0) && (!r_live[r_head] || updReady_i);

   always_comb begin
      w_free  = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);
      w_used  = '0;
      w_drops = '0;
      w_acc   = '0;
      for (int p = 0; p < NUM_PIPES; p++) begin
         w_off[p] = w_used[PTR_W-1:0];
         if (exeCtrlValid_i[p] && !exceptionFlag_i && !(recoverFlag_i && w_in_younger[p])) begin
            if (w_used < w_free) begin
               w_acc[p] = 1'b1;
               w_used   = w_used + CNT_W'(1);
            end else begin
               w_drops  = w_drops + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      w_drop_sum  = {1'b0, r_drop_cnt} + (DROP_CNT_W+1)'(w_drops);
      w_drop_next = w_drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : w_drop_sum[DROP_CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_live     <= '0;
         r_drop_cnt <= '0;
         for (int e = 0; e < DEPTH; e++) r_entry[e] <= '0;
      end else begin
         r_drop_cnt <= w_drop_next;
         if (exceptionFlag_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_live  <= '0;
         end else begin
            for (int e = 0; e < DEPTH; e++) begin
               if (recoverFlag_i && w_ent_younger[e]) r_live[e] <= 1'b0;
            end
            if (w_pop) begin
               r_live[r_head] <= 1'b0;
               r_head         <= r_head + PTR_W'(1);
            end
            // New writes come last: at full they land in the slot the pop just freed.
            for (int p = 0; p < NUM_PIPES; p++) begin
               if (w_acc[p]) begin
                  r_entry[r_tail + w_off[p]] <= w_in_pkt[p];
                  r_live[r_tail + w_off[p]]  <= 1'b1;
               end
            end
            r_tail  <= r_tail + w_used[PTR_W-1:0];
            r_count <= r_count + w_used - CNT_W'(w_pop);
         end
      end
   end

endmodule

// File: tb/tb_ctrl_resolve_buffer.sv
// tb/tb_ctrl_resolve_buffer.sv - scoreboard bench for ctrl_resolve_buffer
module tb_ctrl_resolve_buffer;
   import ctrl_resolve_buffer_pkg::*;

   localparam int NP  = 2;
   localparam int DEP = 8;
   localparam int DW  = 16;

   logic                             clk = 1'b0;
   logic                             reset;
   logic                             exceptionFlag_i;
   logic                             recoverFlag_i;
   logic [SIZE_CTI_LOG-1:0]          recoverCtiID_i;
   logic [SIZE_CTI_LOG-1:0]          ctiHead_i;
   logic [NP-1:0]                    exeCtrlValid_i;
   logic [NP*SIZE_PC-1:0]            exeCtrlPC_i;
   logic [NP*SIZE_PC-1:0]            exeCtrlNPC_i;
   logic [NP*BRANCH_TYPE_LOG-1:0]    exeCtrlType_i;
   logic [NP-1:0]                    exeCtrlDir_i;
   logic [NP*SIZE_CTI_LOG-1:0]       exeCtiID_i;
   logic                             updReady_i;
   logic                             updValid_o;
   ctrlUpdPkt                        updPkt_o;
   logic [$clog2(DEP):0]             occupancy_o;
   logic [DW-1:0]                    dropCnt_o;

   ctrl_resolve_buffer #(.NUM_PIPES(NP), .DEPTH(DEP), .DROP_CNT_W(DW)) dut (
      .clk             (clk),
      .reset           (reset),
      .exceptionFlag_i (exceptionFlag_i),
      .recoverFlag_i   (recoverFlag_i),
      .recoverCtiID_i  (recoverCtiID_i),
      .ctiHead_i       (ctiHead_i),
      .exeCtrlValid_i  (exeCtrlValid_i),
      .exeCtrlPC_i     (exeCtrlPC_i),
      .exeCtrlNPC_i    (exeCtrlNPC_i),
      .exeCtrlType_i   (exeCtrlType_i),
      .exeCtrlDir_i    (exeCtrlDir_i),
      .exeCtiID_i      (exeCtiID_i),
      .updReady_i      (updReady_i),
      .updValid_o      (updValid_o),
      .updPkt_o        (updPkt_o),
      .occupancy_o     (occupancy_o),
      .dropCnt_o       (dropCnt_o)
   );

   always #5 clk = ~clk;

   int        n_pass  = 0;
   int        n_total = 0;
   int        seq     = 0;
   ctrlUpdPkt sb [$];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic ctrlUpdPkt mk(input logic [SIZE_CTI_LOG-1:0] id, input int s);
      ctrlUpdPkt k;
      k.pc       = 32'h1000_0000 + SIZE_PC'(s * 16);
      k.npc      = 32'h2000_0000 + SIZE_PC'(s * 36);
      k.ctrlType = BRANCH_TYPE_LOG'(s);
      k.dir      = s[0];
      k.ctiID    = id;
      return k;
   endfunction

   task automatic set_pipe(input int p, input ctrlUpdPkt k);
      exeCtrlPC_i[p*SIZE_PC +: SIZE_PC]                 = k.pc;
      exeCtrlNPC_i[p*SIZE_PC +: SIZE_PC]                = k.npc;
      exeCtrlType_i[p*BRANCH_TYPE_LOG +: BRANCH_TYPE_LOG] = k.ctrlType;
      exeCtrlDir_i[p]                                   = k.dir;
      exeCtiID_i[p*SIZE_CTI_LOG +: SIZE_CTI_LOG]        = k.ctiID;
   endtask

   // acc0/acc1 say whether the bench expects that pipe to reach the predictor.
   task automatic drive(input logic v0, input logic [3:0] id0, input logic acc0,
                        input logic v1, input logic [3:0] id1, input logic acc1);
      ctrlUpdPkt k0, k1;
      k0 = mk(id0, seq); seq++;
      k1 = mk(id1, seq); seq++;
      set_pipe(0, k0);
      set_pipe(1, k1);
      exeCtrlValid_i = {v1, v0};
      if (v0 && acc0) sb.push_back(k0);
      if (v1 && acc1) sb.push_back(k1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      exeCtrlValid_i  = '0;
      recoverFlag_i   = 1'b0;
      exceptionFlag_i = 1'b0;
   endtask

   task automatic drain(input string tag, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (occupancy_o == 0) break;
         tick();
      end
      chk(tag, occupancy_o, 0);
      chk({tag, "_sb"}, sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!reset && updValid_o && updReady_i) begin
         if (sb.size() == 0) chk("sb_underflow", 1, 0);
         else chk("upd_pkt", updPkt_o, sb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; exceptionFlag_i = 1'b0; recoverFlag_i = 1'b0;
      recoverCtiID_i = '0; ctiHead_i = '0; exeCtrlValid_i = '0;
      exeCtrlPC_i = '0; exeCtrlNPC_i = '0; exeCtrlType_i = '0;
      exeCtrlDir_i = '0; exeCtiID_i = '0; updReady_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_occ", occupancy_o, 0);
      chk("rst_valid", updValid_o, 0);
      chk("rst_drop", dropCnt_o, 0);
      chk("rst_pkt", updPkt_o, 0);

      // Two pipes, ready predictor: updates 3 then 4, one cycle latency.
      updReady_i = 1'b1;
      drive(1, 3, 1, 1, 4, 1);
      chk("t1_no_bypass", updValid_o, 0);
      tick();
      chk("t1_valid", updValid_o, 1);
      chk("t1_occ2", occupancy_o, 2);
      tick();
      chk("t1_occ1", occupancy_o, 1);
      tick();
      chk("t1_occ0", occupancy_o, 0);
      chk("t1_sb", sb.size(), 0);

      // Stalled predictor fills the buffer; one entry preloaded.
      updReady_i = 1'b0;
      drive(1, 1, 1, 0, 0, 0);
      tick();
      for (int c = 0; c < 5; c++) begin
         drive(1, 4'(2*c), c < 4, 1, 4'(2*c+1), c < 3);
         tick();
         if (c == 3) chk("t2_full_c4", occupancy_o, 8);
      end
      chk("t2_occ", occupancy_o, 8);
      chk("t2_drop", dropCnt_o, 3);

      // Full with pop and push in the same cycle.
      updReady_i = 1'b1;
      drive(1, 9, 1, 0, 0, 0);
      tick();
      chk("t3_occ", occupancy_o, 8);
      chk("t3_drop", dropCnt_o, 3);
      drain("t3_drain", 20);

      // Recovery across the CTI wrap.
      updReady_i = 1'b0;
      ctiHead_i  = 4'd14;
      drive(1, 14, 1, 1, 15, 1);
      tick();
      drive(1, 0, 0, 1, 1, 0);
      tick();
      chk("t4_occ4", occupancy_o, 4);
      recoverFlag_i  = 1'b1;
      recoverCtiID_i = 4'd15;
      drive(1, 1, 0, 1, 15, 1);
      tick();
      chk("t4_occ5", occupancy_o, 5);
      chk("t4_drop", dropCnt_o, 3);
      updReady_i = 1'b1;
      tick();
      tick();
      chk("t4_dead1_valid", updValid_o, 0);
      chk("t4_dead1_occ", occupancy_o, 3);
      tick();
      chk("t4_dead2_valid", updValid_o, 0);
      chk("t4_dead2_occ", occupancy_o, 2);
      tick();
      chk("t4_live_valid", updValid_o, 1);
      chk("t4_live_occ", occupancy_o, 1);
      drain("t4_drain", 5);

      // Exception overrides recovery and discards same-cycle inputs.
      ctiHead_i  = '0;
      updReady_i = 1'b0;
      drive(1, 2, 0, 1, 3, 0);
      tick();
      chk("t5_occ2", occupancy_o, 2);
      recoverFlag_i   = 1'b1;
      recoverCtiID_i  = 4'd2;
      exceptionFlag_i = 1'b1;
      drive(1, 4, 0, 1, 5, 0);
      tick();
      chk("t5_occ", occupancy_o, 0);
      chk("t5_valid", updValid_o, 0);
      chk("t5_drop", dropCnt_o, 3);
      tick();
      chk("t5_occ_after", occupancy_o, 0);

      // Mid-operation reset.
      for (int c = 0; c < 4; c++) begin
         drive(1, 4'(c), 1, 1, 4'(c+8), 1);
         tick();
      end
      for (int c = 0; c < 2; c++) begin
         drive(1, 6, 0, 1, 7, 0);
         tick();
      end
      chk("t6_drop7", dropCnt_o, 7);
      updReady_i = 1'b1;
      repeat (3) tick();
      updReady_i = 1'b0;
      chk("t6_occ5", occupancy_o, 5);
      sb.delete();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_occ", occupancy_o, 0);
      chk("t6_valid", updValid_o, 0);
      chk("t6_drop", dropCnt_o, 0);
      updReady_i = 1'b1;
      drive(1, 7, 1, 0, 0, 0);
      tick();
      chk("t6_post_valid", updValid_o, 1);
      drain("t6_drain", 5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
